// File: rtl/ttl74x491_modn_counter.sv
// ---------------------------------------------------------------------------
// ttl74x491_modn_counter
//
// Bidirectional binary counter with a programmable modulus. It is the
// drop-in successor for discrete up/down counter chips in the TTL-replacement
// library.
//
// Counting behaviour:
//   - Counting up, the counter runs 0..LIMIT and then wraps to 0.
//   - Counting down, it runs LIMIT..0 and then wraps to LIMIT.
//   - Each wrap produces a one-cycle registered WRAP pulse and sets the
//     sticky OVF flag.
//   - Stages cascade by feeding one stage's RCO_n into the next stage's CET_n.
//
// Optional build macro: TTL491_PRESCALE_EN
//   - When defined, an internal prescaler divides the enabled clocks.
//   - The counter then steps once every PRESCALE enabled clocks.
//   - When undefined, the counter steps on every enabled clock and the
//     PRESCALE parameter has no effect.
//
// Parameters
//   DATA_WIDTH  counter / limit / data width in bits (>= 2)
//   PRESCALE    enabled clocks per count step when prescaling (>= 2)
//
// Ports
//   clk       in   rising-edge clock
//   RST_n     in   asynchronous active-low reset
//   SET       in   synchronous set, Q <= all ones (highest priority)
//   LD_n      in   synchronous load, active low, Q <= D
//   LIM_LD_n  in   synchronous limit load, active low, LIMIT <= D
//   CNT_n     in   count enable, active low
//   CET_n     in   cascade enable in, active low
//   UP_n      in   direction, 0 = up, 1 = down
//   OVF_CLR   in   synchronous clear of OVF
//   D         in   parallel data for LD_n / LIM_LD_n
//   Q         out  counter value
//   LIMIT     out  current limit register
//   TC        out  terminal count (combinational)
//   RCO_n     out  ripple carry out, active low (combinational)
//   WRAP      out  one-cycle pulse in the cycle after a wrapping step
//   OVF       out  sticky wrap flag
// ---------------------------------------------------------------------------
module ttl74x491_modn_counter #(
    parameter int DATA_WIDTH = 10,
    parameter int PRESCALE   = 4
) (
    input  logic                  clk,
    input  logic                  RST_n,
    input  logic                  SET,
    input  logic                  LD_n,
    input  logic                  LIM_LD_n,
    input  logic                  CNT_n,
    input  logic                  CET_n,
    input  logic                  UP_n,
    input  logic                  OVF_CLR,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic [DATA_WIDTH-1:0] LIMIT,
    output logic                  TC,
    output logic                  RCO_n,
    output logic                  WRAP,
    output logic                  OVF
);

    localparam logic [DATA_WIDTH-1:0] ZERO     = '0;
    localparam logic [DATA_WIDTH-1:0] ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

    logic [DATA_WIDTH-1:0] q_reg;
    logic [DATA_WIDTH-1:0] q_next;
    logic [DATA_WIDTH-1:0] lim_reg;
    logic [DATA_WIDTH-1:0] lim_next;
    logic                  wrap_reg;
    logic                  wrap_next;
    logic                  ovf_reg;
    logic                  ovf_next;

    // Raw enable from the two active-low enable pins.
    logic cnt_en;

    // Qualified enable: the clock on which a count step is actually allowed.
    logic step_en;

    // Terminal count of the current value in the current direction.
    logic at_term;

    // A load or set this edge overrides any count step.
    logic load_override;

    assign cnt_en        = ~CNT_n & ~CET_n;
    assign load_override = SET | ~LD_n;

    // Counting up, any value at or above the limit is terminal. This makes a
    // value loaded above the limit wrap to 0 on the next up step.
    assign at_term = UP_n ? (q_reg == ZERO) : (q_reg >= lim_reg);

`ifdef TTL491_PRESCALE_EN
    // -----------------------------------------------------------------------
    // Prescaler
    //   - Advances only while the raw enable is active.
    //   - The counter steps on the terminal prescaler phase.
    //   - A set or load restarts the phase so the next step is a full
    //     PRESCALE clocks away.
    // -----------------------------------------------------------------------
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRESC_ONE  = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] presc_reg;
    logic [PW-1:0] presc_next;

    assign step_en = cnt_en & (presc_reg == PRESC_LAST);

    always_comb begin
        presc_next = presc_reg;
        if (load_override) begin
            presc_next = '0;
        end else if (cnt_en) begin
            presc_next = step_en ? '0 : (presc_reg + PRESC_ONE);
        end
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_next;
        end
    end
`else
    // No prescaler: step on every enabled clock. PRESCALE is folded into a
    // deliberately unused net so the parameter stays referenced.
    logic unused_prescale;

    assign unused_prescale = ^PRESCALE;
    assign step_en         = cnt_en;
`endif

    // -----------------------------------------------------------------------
    // Counter next state
    //   Priority: SET > LD_n > count step > hold.
    //   The limit register updates independently of this chain, so a limit
    //   load on the same edge as a step still compares against the old limit.
    // -----------------------------------------------------------------------
    always_comb begin
        q_next    = q_reg;
        wrap_next = 1'b0;

        if (SET) begin
            q_next = ALL_ONES;
        end else if (!LD_n) begin
            q_next = D;
        end else if (step_en) begin
            if (!UP_n) begin
                if (q_reg >= lim_reg) begin
                    q_next    = ZERO;
                    wrap_next = 1'b1;
                end else begin
                    q_next = q_reg + ONE;
                end
            end else begin
                if (q_reg == ZERO) begin
                    q_next    = lim_reg;
                    wrap_next = 1'b1;
                end else begin
                    // A value above the limit simply counts down towards it.
                    q_next = q_reg - ONE;
                end
            end
        end
    end

    assign lim_next = LIM_LD_n ? lim_reg : D;

    // A wrap on the same edge as OVF_CLR leaves OVF set, so no wrap event is
    // ever lost by a coincident clear.
    always_comb begin
        ovf_next = ovf_reg;
        if (wrap_next) begin
            ovf_next = 1'b1;
        end else if (OVF_CLR) begin
            ovf_next = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            q_reg    <= ZERO;
            lim_reg  <= ALL_ONES;
            wrap_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            q_reg    <= q_next;
            lim_reg  <= lim_next;
            wrap_reg <= wrap_next;
            ovf_reg  <= ovf_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    //   TC and RCO_n are combinational so that a cascade of stages resolves
    //   within one clock period.
    // -----------------------------------------------------------------------
    assign Q     = q_reg;
    assign LIMIT = lim_reg;
    assign WRAP  = wrap_reg;
    assign OVF   = ovf_reg;
    assign TC    = at_term;
    assign RCO_n = ~(at_term & step_en);

endmodule

// File: tb/tb_ttl74x491_modn_counter.sv
// ---------------------------------------------------------------------------
// tb_ttl74x491_modn_counter
//
// Self-checking bench for ttl74x491_modn_counter.
//
// Stimulus and checking:
//   - Table vectors carry hand-derived expected outputs.
//   - Each vector's expectation is pushed to a scoreboard queue when the
//     vector is driven.
//   - The expectation is popped and compared one time unit after the
//     following rising edge.
//
// Hand-written sequences cover:
//   - asynchronous reset in the middle of a count;
//   - an 8-bit cascade built from two 4-bit stages;
//   - the prescaled build (TTL491_PRESCALE_EN).
// ---------------------------------------------------------------------------
module tb_ttl74x491_modn_counter;

    localparam int W = 10;

    typedef struct {
        logic         set;
        logic         ld_n;
        logic         lim_ld_n;
        logic         cnt_n;
        logic         cet_n;
        logic         up_n;
        logic         ovf_clr;
        logic [W-1:0] d;
        logic [W-1:0] q;
        logic [W-1:0] lim;
        logic         wrap;
        logic         ovf;
        logic         tc;
        logic         rco_n;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         set;
    logic         ld_n;
    logic         lim_ld_n;
    logic         cnt_n;
    logic         cet_n;
    logic         up_n;
    logic         ovf_clr;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] limit;
    logic         tc;
    logic         rco_n;
    logic         wrap;
    logic         ovf;

    // Two 4-bit stages forming an 8-bit cascade.
    logic       c_cnt_n;
    logic [3:0] c1_q;
    logic [3:0] c1_lim;
    logic [3:0] c2_q;
    logic [3:0] c2_lim;
    logic       c1_tc;
    logic       c1_rco_n;
    logic       c1_wrap;
    logic       c1_ovf;
    logic       c2_tc;
    logic       c2_rco_n;
    logic       c2_wrap;
    logic       c2_ovf;

    int total = 0;
    int bad   = 0;

    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    ttl74x491_modn_counter #(.DATA_WIDTH(W), .PRESCALE(4)) dut (
        .clk(clk), .RST_n(rst_n), .SET(set), .LD_n(ld_n), .LIM_LD_n(lim_ld_n),
        .CNT_n(cnt_n), .CET_n(cet_n), .UP_n(up_n), .OVF_CLR(ovf_clr), .D(d),
        .Q(q), .LIMIT(limit), .TC(tc), .RCO_n(rco_n), .WRAP(wrap), .OVF(ovf)
    );

    ttl74x491_modn_counter #(.DATA_WIDTH(4), .PRESCALE(4)) stage1 (
        .clk(clk), .RST_n(rst_n), .SET(1'b0), .LD_n(1'b1), .LIM_LD_n(1'b1),
        .CNT_n(c_cnt_n), .CET_n(1'b0), .UP_n(1'b0), .OVF_CLR(1'b0), .D(4'h0),
        .Q(c1_q), .LIMIT(c1_lim), .TC(c1_tc), .RCO_n(c1_rco_n),
        .WRAP(c1_wrap), .OVF(c1_ovf)
    );

    ttl74x491_modn_counter #(.DATA_WIDTH(4), .PRESCALE(4)) stage2 (
        .clk(clk), .RST_n(rst_n), .SET(1'b0), .LD_n(1'b1), .LIM_LD_n(1'b1),
        .CNT_n(c_cnt_n), .CET_n(c1_rco_n), .UP_n(1'b0), .OVF_CLR(1'b0), .D(4'h0),
        .Q(c2_q), .LIMIT(c2_lim), .TC(c2_tc), .RCO_n(c2_rco_n),
        .WRAP(c2_wrap), .OVF(c2_ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic vec_t mk(
        input logic s, input logic l, input logic ll, input logic c, input logic ce,
        input logic u, input logic oc, input logic [W-1:0] dd,
        input logic [W-1:0] eq, input logic [W-1:0] el, input logic ew,
        input logic eo, input logic et, input logic er);
        vec_t v;
        v.set = s;  v.ld_n = l;   v.lim_ld_n = ll; v.cnt_n = c; v.cet_n = ce;
        v.up_n = u; v.ovf_clr = oc; v.d = dd;
        v.q = eq;   v.lim = el;   v.wrap = ew;     v.ovf = eo;  v.tc = et; v.rco_n = er;
        return v;
    endfunction

    task automatic idle_inputs();
        set = 1'b0; ld_n = 1'b1; lim_ld_n = 1'b1; cnt_n = 1'b1; cet_n = 1'b0;
        up_n = 1'b0; ovf_clr = 1'b0; d = '0;
    endtask

    task automatic drive(input vec_t v);
        set = v.set; ld_n = v.ld_n; lim_ld_n = v.lim_ld_n; cnt_n = v.cnt_n;
        cet_n = v.cet_n; up_n = v.up_n; ovf_clr = v.ovf_clr; d = v.d;
    endtask

    // Watchdog: the bench never waits on a DUT event, but bound the run anyway.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t e;
        logic [7:0] cexp;

        idle_inputs();
        c_cnt_n = 1'b1;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state.
        chk("rst_q", q, 0);
        chk("rst_limit", limit, 10'h3FF);
        chk("rst_wrap", wrap, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_tc", tc, 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef TTL491_PRESCALE_EN
        // Columns: set ld lim cnt cet up clr d | q lim wrap ovf tc rco_n
        tbl.push_back(mk(0,1,0,1,0,0,0,10'd5,    10'd0,  10'd5,0,0,0,1)); // limit=5
        tbl.push_back(mk(0,1,1,0,0,0,0,10'd0,    10'd1,  10'd5,0,0,0,1));
        tbl.push_back(mk(0,1,1,0,0,0,0,10'd0,    10'd2,  10'd5,0,0,0,1));
        tbl.push_back(mk(0,1,1,0,0,0,0,10'd0,    10'd3,  10'd5,0,0,0,1));
        tbl.push_back(mk(0,1,1,0,0,0,0,10'd0,    10'd4,  10'd5,0,0,0,1));
        tbl.push_back(mk(0,1,1,0,0,0,0,10'd0,    10'd5,  10'd5,0,0,1,0)); // at limit
        tbl.push_back(mk(0,1,1,0,0,0,0,10'd0,    10'd0,  10'd5,1,1,0,1)); // 5->0 wrap
        tbl.push_back(mk(0,1,1,0,0,0,0,10'd0,    10'd1,  10'd5,0,1,0,1));
        tbl.push_back(mk(0,1,1,0,0,0,0,10'd0,    10'd2,  10'd5,0,1,0,1));
        tbl.push_back(mk(0,1,1,1,0,0,1,10'd0,    10'd2,  10'd5,0,0,0,1)); // clear OVF
        tbl.push_back(mk(0,0,1,1,0,1,0,10'd0,    10'd0,  10'd5,0,0,1,1)); // load 0, TC idle
        tbl.push_back(mk(0,1,1,0,0,1,0,10'd0,    10'd5,  10'd5,1,1,0,1)); // down 0->5 wrap
        tbl.push_back(mk(0,1,1,0,0,1,0,10'd0,    10'd4,  10'd5,0,1,0,1));
        tbl.push_back(mk(1,0,1,0,0,0,0,10'h055,  10'h3FF,10'd5,0,1,1,0)); // SET beats LD
        tbl.push_back(mk(0,0,1,0,0,0,0,10'h055,  10'h055,10'd5,0,1,1,0)); // LD beats step
        tbl.push_back(mk(0,1,1,0,0,0,0,10'd0,    10'd0,  10'd5,1,1,0,1)); // above limit -> 0
        tbl.push_back(mk(0,1,1,1,0,0,1,10'd0,    10'd0,  10'd5,0,0,0,1));
        tbl.push_back(mk(0,1,0,1,0,0,0,10'd0,    10'd0,  10'd0,0,0,1,1)); // limit=0
        tbl.push_back(mk(0,1,1,0,0,0,0,10'd0,    10'd0,  10'd0,1,1,1,0)); // up wrap at 0
        tbl.push_back(mk(0,1,1,0,0,1,1,10'd0,    10'd0,  10'd0,1,1,1,0)); // down wrap beats clr
        tbl.push_back(mk(0,1,1,1,0,1,1,10'd0,    10'd0,  10'd0,0,0,1,1));
        tbl.push_back(mk(0,0,0,1,0,0,0,10'd3,    10'd3,  10'd3,0,0,1,1)); // LD + LIM_LD together
        tbl.push_back(mk(0,1,1,0,0,1,0,10'd0,    10'd2,  10'd3,0,0,0,1));
        tbl.push_back(mk(0,1,1,0,1,0,0,10'd0,    10'd2,  10'd3,0,0,0,1)); // CET_n blocks

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_q", i), q, e.q);
            chk($sformatf("v%0d_limit", i), limit, e.lim);
            chk($sformatf("v%0d_wrap", i), wrap, e.wrap);
            chk($sformatf("v%0d_ovf", i), ovf, e.ovf);
            chk($sformatf("v%0d_tc", i), tc, e.tc);
            chk($sformatf("v%0d_rco_n", i), rco_n, e.rco_n);
            $display("vec %0d: q=%0h limit=%0h wrap=%0b ovf=%0b tc=%0b rco_n=%0b",
                     i, q, limit, wrap, ovf, tc, rco_n);
        end

        // Asynchronous reset mid-count: reach Q=37 with OVF set.
        @(negedge clk);
        idle_inputs();
        ld_n = 1'b0; lim_ld_n = 1'b0; d = 10'd37;
        @(negedge clk);
        idle_inputs();
        cnt_n = 1'b0;                         // 37 >= 37 -> wrap, OVF=1
        @(negedge clk);
        idle_inputs();
        ld_n = 1'b0; d = 10'd37;
        @(negedge clk);
        idle_inputs();
        chk("pre_rst_q", q, 37);
        chk("pre_rst_ovf", ovf, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_q", q, 0);
        chk("async_rst_limit", limit, 10'h3FF);
        chk("async_rst_ovf", ovf, 0);
        chk("async_rst_wrap", wrap, 0);
        $display("async reset: q=%0h limit=%0h ovf=%0b", q, limit, ovf);
        @(negedge clk);
        rst_n = 1'b1;

        // 8-bit cascade from two 4-bit stages; both limits reset to 15.
        chk("casc_start", {c2_q, c1_q}, 0);
        for (int k = 1; k <= 257; k++) begin
            @(negedge clk);
            c_cnt_n = 1'b0;
            @(posedge clk);
            #1;
            cexp = 8'(k);
            chk($sformatf("casc_%0d", k), {c2_q, c1_q}, cexp);
            if (k >= 254) begin
                $display("cascade step %0d: value=%0h", k, {c2_q, c1_q});
            end
        end
        @(negedge clk);
        c_cnt_n = 1'b1;
`else
        // Prescaled build: LIMIT=2, one step every 4 enabled clocks.
        @(negedge clk);
        lim_ld_n = 1'b0; d = 10'd2;
        @(posedge clk);
        #1;
        chk("ps_limit", limit, 2);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            idle_inputs();
            cnt_n   = 1'b0;
            ovf_clr = (k == 12);
            @(posedge clk);
            #1;
            chk($sformatf("ps_q_%0d", k), q, (k / 4) % 3);
            chk($sformatf("ps_wrap_%0d", k), wrap, (k == 12) ? 1 : 0);
            chk($sformatf("ps_ovf_%0d", k), ovf, (k == 12) ? 1 : 0);
            $display("prescale clock %0d: q=%0h wrap=%0b ovf=%0b", k, q, wrap, ovf);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
